// File: rtl/score_pkg.sv
// Shared constants and helpers for the score path: BCD limits, default
// per-enemy point values and a popcount used to count kills.
package score_pkg;

  localparam int unsigned BCD_DIGITS = 4;
  localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

  localparam int unsigned FLY_POINTS_DEF      = 1;
  localparam int unsigned MOSQUITO_POINTS_DEF = 2;
  localparam int unsigned SPIDER_POINTS_DEF   = 10;

  // Callers zero-extend narrower kill vectors into the 32-bit argument.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n += 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/score_controller_if.sv
// Bundle between the enemy/game side (master) and the score controller (slave).
interface score_controller_if #(
  parameter int unsigned FLY_COUNT      = 4,
  parameter int unsigned MOSQUITO_COUNT = 8
);
  logic                      score_clear;
  logic [FLY_COUNT-1:0]      fly_alive;
  logic [MOSQUITO_COUNT-1:0] mosquito_alive;
  logic                      spider_alive;
  logic [15:0]               score_bcd;
  logic [15:0]               high_score_bcd;
  logic                      kill_pulse;
  logic                      busy;

  modport master (
    output score_clear, fly_alive, mosquito_alive, spider_alive,
    input  score_bcd, high_score_bcd, kill_pulse, busy
  );

  modport slave (
    input  score_clear, fly_alive, mosquito_alive, spider_alive,
    output score_bcd, high_score_bcd, kill_pulse, busy
  );
endinterface

// File: rtl/bcd_inc4.sv
// Combinational 4-digit BCD increment; holds at 9999 and flags saturation.
module bcd_inc4
  import score_pkg::*;
(
  input  logic [15:0] bcd_in,
  output logic [15:0] bcd_out,
  output logic        sat
);

  always_comb begin
    logic carry;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    carry   = 1'b1;
    bcd_out = bcd_in;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (bcd_in[4*i +: 4] == 4'd9) begin
          bcd_out[4*i +: 4] = 4'd0;
        end else begin
          bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    sat = (bcd_in == SCORE_MAX_BCD);
    if (sat) bcd_out = SCORE_MAX_BCD;
  end

endmodule

// File: rtl/score_controller.sv
// Turns falling edges on enemy alive flags into weighted points, drains them
// into a BCD score one point per cycle, and keeps the high score.
module score_controller
  import score_pkg::*;
#(
  parameter int unsigned FLY_COUNT       = 4,
  parameter int unsigned MOSQUITO_COUNT  = 8,
  parameter int unsigned FLY_POINTS      = FLY_POINTS_DEF,
  parameter int unsigned MOSQUITO_POINTS = MOSQUITO_POINTS_DEF,
  parameter int unsigned SPIDER_POINTS   = SPIDER_POINTS_DEF,
  parameter int unsigned PEND_W          = 8
) (
  input  logic              clk25,
  input  logic              reset,
  score_controller_if.slave bus
);

  localparam logic [16:0] PEND_MAX = 17'((1 << PEND_W) - 1);

  logic [FLY_COUNT-1:0]      prev_fly_q, prev_fly_d, kill_fly;
  logic [MOSQUITO_COUNT-1:0] prev_mos_q, prev_mos_d, kill_mos;
  logic                      prev_spider_q, prev_spider_d, kill_spider;
  logic [PEND_W-1:0]         pending_q, pending_d;
  logic [15:0]               score_q, score_d, high_q, high_d;
  logic                      kill_q, kill_d, busy_q, busy_d;

  logic [15:0] add_pts, inc_out;
  logic [16:0] pend_sum;
  logic        inc_sat, dec;

  bcd_inc4 u_inc (
    .bcd_in  (score_q),
    .bcd_out (inc_out),
    .sat     (inc_sat)
  );

  always_comb begin
    kill_fly    = prev_fly_q & ~bus.fly_alive;
    kill_mos    = prev_mos_q & ~bus.mosquito_alive;
    kill_spider = prev_spider_q & ~bus.spider_alive;
    add_pts     = 16'(popcount(32'(kill_fly))) * 16'(FLY_POINTS)
                + 16'(popcount(32'(kill_mos))) * 16'(MOSQUITO_POINTS)
                + (kill_spider ? 16'(SPIDER_POINTS) : 16'd0);
    dec         = (pending_q != '0);
    pend_sum    = 17'(pending_q) - 17'(dec) + 17'(add_pts);

    prev_fly_d    = bus.fly_alive;
    prev_mos_d    = bus.mosquito_alive;
    prev_spider_d = bus.spider_alive;
    kill_d        = (|kill_fly) | (|kill_mos) | kill_spider;
    score_d       = score_q;
    high_d        = high_q;
    pending_d     = pending_q;

    if (bus.score_clear) begin
      // Kills seen in the clear cycle are dropped; only the pulse survives.
      if (score_q > high_q) high_d = score_q;
      score_d   = '0;
      pending_d = '0;
    end else if (dec && inc_sat) begin
      pending_d = '0;
    end else begin
      if (dec) score_d = inc_out;
      pending_d = (pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];
    end

    busy_d = (pending_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk25) begin
    if (reset) begin
      prev_fly_q    <= '0;
      prev_mos_q    <= '0;
      prev_spider_q <= 1'b0;
      pending_q     <= '0;
      score_q       <= '0;
      high_q        <= '0;
      kill_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      prev_fly_q    <= prev_fly_d;
      prev_mos_q    <= prev_mos_d;
      prev_spider_q <= prev_spider_d;
      pending_q     <= pending_d;
      score_q       <= score_d;
      high_q        <= high_d;
      kill_q        <= kill_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.score_bcd      = score_q;
  assign bus.high_score_bcd = high_q;
  assign bus.kill_pulse     = kill_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_score_controller.sv
// Scoreboard bench for score_controller: a decimal reference model predicts
// each cycle's outputs, which are queued at drive time and compared after the edge.
module tb_score_controller;

  logic clk25;
  logic reset;

  score_controller_if #(.FLY_COUNT(4), .MOSQUITO_COUNT(8)) bus ();

  score_controller dut (
    .clk25 (clk25),
    .reset (reset),
    .bus   (bus)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  typedef struct packed {
    logic [15:0] score;
    logic [15:0] high;
    logic        kill;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  int         m_score, m_high, m_pend;
  logic [3:0] m_pfly;
  logic [7:0] m_pmos;
  logic       m_pspi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Predict the post-edge outputs from current inputs, then clock and compare.
  task automatic tick();
    exp_t e;
    logic [3:0] kf;
    logic [7:0] km;
    logic       ks;
    int         add, nxt;
    if (reset) begin
      m_score = 0; m_high = 0; m_pend = 0;
      m_pfly = '0; m_pmos = '0; m_pspi = 1'b0;
      e.kill = 1'b0;
    end else begin
      kf  = m_pfly & ~bus.fly_alive;
      km  = m_pmos & ~bus.mosquito_alive;
      ks  = m_pspi & ~bus.spider_alive;
      add = $countones(kf) * 1 + $countones(km) * 2 + (ks ? 10 : 0);
      e.kill = (kf != 0) || (km != 0) || ks;
      if (bus.score_clear) begin
        if (m_score > m_high) m_high = m_score;
        m_score = 0;
        m_pend  = 0;
      end else if (m_pend != 0 && m_score == 9999) begin
        m_pend = 0;
      end else begin
        nxt = m_pend + add;
        if (m_pend != 0) begin
          m_score++;
          nxt--;
        end
        m_pend = (nxt > 255) ? 255 : nxt;
      end
      m_pfly = bus.fly_alive;
      m_pmos = bus.mosquito_alive;
      m_pspi = bus.spider_alive;
    end
    e.score = to_bcd(m_score);
    e.high  = to_bcd(m_high);
    e.busy  = (m_pend != 0);
    exp_q.push_back(e);

    @(posedge clk25);
    @(negedge clk25);
    e = exp_q.pop_front();
    check("sb_score", 32'(bus.score_bcd), 32'(e.score));
    check("sb_high",  32'(bus.high_score_bcd), 32'(e.high));
    check("sb_kill",  32'(bus.kill_pulse), 32'(e.kill));
    check("sb_busy",  32'(bus.busy), 32'(e.busy));
  endtask

  task automatic raise_all();
    bus.fly_alive      = 4'hF;
    bus.mosquito_alive = 8'hFF;
    bus.spider_alive   = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.busy; i++) tick();
    check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  // Adds exactly n points via kills, assuming all flags start high.
  task automatic score_up(input int n);
    int burst, sp, m, f;
    while (n > 0) begin
      burst = 0;
      while (n >= 30 && burst < 8) begin
        bus.fly_alive = '0; bus.mosquito_alive = '0; bus.spider_alive = 1'b0;
        tick();
        raise_all();
        tick();
        n -= 30;
        burst++;
      end
      if (burst == 0) begin
        sp = (n >= 10) ? 1 : 0;
        n -= 10 * sp;
        m  = (n / 2 > 8) ? 8 : n / 2;
        f  = n - 2 * m;
        bus.fly_alive      = 4'(4'hF << f);
        bus.mosquito_alive = 8'(8'hFF << m);
        bus.spider_alive   = (sp == 0);
        tick();
        raise_all();
        tick();
        n = 0;
      end
      wait_idle(300);
    end
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    reset = 1'b1;
    bus.score_clear    = 1'b0;
    bus.fly_alive      = '0;
    bus.mosquito_alive = '0;
    bus.spider_alive   = 1'b0;
    tick();
    tick();
    check("rst_score", 32'(bus.score_bcd), 32'h0);
    check("rst_high",  32'(bus.high_score_bcd), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);

    // Release with all enemies present: prev was 0, so no false kill.
    reset = 1'b0;
    raise_all();
    tick();
    check("no_false_kill", 32'(bus.kill_pulse), 32'h0);

    // Single fly kill.
    bus.fly_alive = 4'b1011;
    tick();
    check("fly2_pulse", 32'(bus.kill_pulse), 32'h1);
    raise_all();
    tick();
    check("fly2_pulse_off", 32'(bus.kill_pulse), 32'h0);
    check("fly2_score", 32'(bus.score_bcd), 32'h0001);
    check("fly2_busy", 32'(bus.busy), 32'h0);

    // Simultaneous fly + two mosquitoes = 5 points, one pulse.
    bus.fly_alive      = 4'b1110;
    bus.mosquito_alive = 8'b1101_0111;
    tick();
    check("multi_pulse", 32'(bus.kill_pulse), 32'h1);
    busy_cnt = bus.busy ? 1 : 0;
    raise_all();
    for (int i = 0; i < 20 && bus.busy; i++) begin
      tick();
      if (bus.busy) busy_cnt++;
    end
    check("multi_busy_cycles", 32'(busy_cnt), 32'd5);
    check("multi_score", 32'(bus.score_bcd), 32'h0006);

    // Digit carry 0009 -> 0010 -> 0019, then 0099 -> 0100.
    score_up(3);
    check("pre_0009", 32'(bus.score_bcd), 32'h0009);
    bus.spider_alive = 1'b0;
    tick();
    raise_all();
    tick();
    check("carry_0010", 32'(bus.score_bcd), 32'h0010);
    repeat (9) tick();
    check("spider_0019", 32'(bus.score_bcd), 32'h0019);
    check("spider_idle", 32'(bus.busy), 32'h0);
    score_up(80);
    check("pre_0099", 32'(bus.score_bcd), 32'h0099);
    score_up(1);
    check("carry_0100", 32'(bus.score_bcd), 32'h0100);

    // High score latching via score_clear.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_high_lost", 32'(bus.high_score_bcd), 32'h0);
    score_up(30);
    bus.score_clear = 1'b1;
    tick();
    bus.score_clear = 1'b0;
    check("clr_high_0030", 32'(bus.high_score_bcd), 32'h0030);
    score_up(42);
    check("pre_0042", 32'(bus.score_bcd), 32'h0042);
    bus.score_clear = 1'b1;
    tick();
    bus.score_clear = 1'b0;
    check("clr_high_0042", 32'(bus.high_score_bcd), 32'h0042);
    check("clr_score", 32'(bus.score_bcd), 32'h0);
    score_up(10);
    bus.score_clear = 1'b1;
    bus.fly_alive   = 4'b1110;
    tick();
    check("clr_keep_high", 32'(bus.high_score_bcd), 32'h0042);
    check("clr_kill_pulse", 32'(bus.kill_pulse), 32'h1);
    check("clr_kill_dropped", 32'(bus.busy), 32'h0);
    bus.score_clear = 1'b0;
    raise_all();
    tick();
    check("clr_score_stays", 32'(bus.score_bcd), 32'h0);

    // Saturation at 9999.
    score_up(9995);
    check("pre_9995", 32'(bus.score_bcd), 32'h9995);
    bus.spider_alive = 1'b0;
    tick();
    raise_all();
    wait_idle(30);
    check("sat_9999", 32'(bus.score_bcd), 32'h9999);
    bus.fly_alive = 4'b1110;
    tick();
    check("sat_pulse", 32'(bus.kill_pulse), 32'h1);
    raise_all();
    tick();
    check("sat_hold", 32'(bus.score_bcd), 32'h9999);
    check("sat_busy", 32'(bus.busy), 32'h0);

    // Reset with 7 points pending, then respawn edges.
    bus.score_clear = 1'b1;
    tick();
    bus.score_clear = 1'b0;
    check("clr_high_9999", 32'(bus.high_score_bcd), 32'h9999);
    bus.fly_alive      = 4'b1110;
    bus.mosquito_alive = 8'b1111_1000;
    tick();
    check("pend7_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    bus.fly_alive = '0; bus.mosquito_alive = '0; bus.spider_alive = 1'b0;
    tick();
    check("midrst_score", 32'(bus.score_bcd), 32'h0);
    check("midrst_high", 32'(bus.high_score_bcd), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    tick();
    raise_all();
    tick();
    check("respawn_no_pulse", 32'(bus.kill_pulse), 32'h0);
    repeat (3) tick();
    check("respawn_score", 32'(bus.score_bcd), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Sits downstream of the fly, mosquito and spider enemy controllers.
- Detects kills as falling edges on the per-enemy alive flags and weights each kill by enemy type.
- Accumulates the weighted points into a 4-digit BCD score, serialised at one point per cycle, and tracks a high score.
- Drives a one-cycle kill pulse for the hit sound and exposes score/high score to the display path.

Parameters:
- FLY_COUNT, 4, number of fly alive flags.
- MOSQUITO_COUNT, 8, number of mosquito alive flags.
- FLY_POINTS, 1, points per fly kill (1..15).
- MOSQUITO_POINTS, 2, points per mosquito kill (1..15).
- SPIDER_POINTS, 10, points per spider kill (1..15).
- PEND_W, 8, width of the pending-points counter.

Ports:
- clk25  in  1  25 MHz pixel-domain clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- score_clear  in  1  new-game strobe; clears score, latches high score.
- fly_alive  in  FLY_COUNT  per-fly alive flags.
- mosquito_alive  in  MOSQUITO_COUNT  per-mosquito alive flags.
- spider_alive  in  1  boss alive flag.
- score_bcd  out  16  current score, 4 BCD digits, [15:12] = thousands.
- high_score_bcd  out  16  best score, BCD.
- kill_pulse  out  1  one-cycle pulse, cycle after any kill is detected.
- busy  out  1  high while pending points != 0.

Behaviour:
- Clock and reset: one clock, clk25. reset is synchronous and active-high.
- Reset values: score_bcd = 0, high_score_bcd = 0, kill_pulse = 0, pending = 0, busy = 0; all prev_alive registers = 0.
- Edge detection:
  - prev_* registers capture the alive inputs every cycle.
  - kill vector = prev & ~alive. Rising edges (respawn after stage reset) are ignored.
  - Because prev resets to 0, no false kill is seen after reset release.
- Add term per cycle: add = popcount(fly kills)*FLY_POINTS + popcount(mosquito kills)*MOSQUITO_POINTS + spider kill*SPIDER_POINTS.
- Counter rules:
  - pending_next = min(pending − dec + add, 2^PEND_W − 1). dec = 1 when pending != 0, else 0.
  - Add and decrement in the same cycle are both honoured.
- Score increment:
  - Each cycle with pending != 0: score_bcd <= BCD(score + 1), per-digit carry, one point per cycle.
  - When score_bcd = 9999, further increments saturate: score holds at 9999 and pending is forced to 0.
- kill_pulse:
  - Registered; asserted on the edge where any kill bit is 1; exactly one cycle per detecting cycle.
  - Multiple simultaneous kills give one pulse.
  - Kills on consecutive cycles give consecutive pulses.
- busy: registered, equals (pending_next != 0).
- Latency: alive drops before edge k → pending and kill_pulse update at edge k → first score increment at edge k+1. An N-point kill with no other activity completes at edge k+N.
- score_clear (when reset is low):
  - high_score_bcd <= max(high_score_bcd, score_bcd), compared as unsigned 16-bit (BCD order is preserved).
  - score_bcd <= 0 and pending <= 0.
  - Kills detected in that cycle are discarded; kill_pulse still follows the kill-detection rule.
  - prev registers update normally.
- Priority: reset > score_clear > increment.
- Mid-operation reset: pending points are dropped and the high score is lost. This is intended: power-on semantics.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package (score_pkg):
  - BCD_DIGITS = 4.
  - SCORE_MAX_BCD = 16'h9999.
  - Default point constants.
  - Popcount function, sized by argument width.
- Sub-module bcd_inc4:
  - Combinational 4-digit BCD +1, with a saturate flag output at 9999.
  - Instantiated once in score_controller; unit-testable on its own.

Test Plan:
- Reset → all outputs 0. Then drop fly_alive[2] 1→0 → kill_pulse 1 for one cycle, score_bcd = 16'h0001 one cycle later, busy low after.
- Drop fly_alive[0], mosquito_alive[3] and mosquito_alive[5] in the same cycle → single kill_pulse, pending = 5, score = 0005 after 5 cycles, busy high for exactly 5 cycles.
- Preload score to 0009, drop spider_alive → score passes 0010 with correct digit carry and ends at 0019. Separately, from 0099 +1 → 0100.
- Drive score to 9995, then 10 points of kills → score saturates at 9999, pending cleared, busy drops. Next kill → pulse only, score stays 9999.
- Score 0042, high score 0030, assert score_clear → high_score = 0042, score = 0000. Repeat with score 0010 → high score stays 0042.
- Raise all alive flags 0→1 (respawn) → no kill_pulse, no score change. Assert reset while pending = 7 → score = 0, pending = 0, no further increments.
